// File: rtl/data_split_pkg.sv
// Shared types and helpers for the registered lane splitter and its skid buffer.
package data_split_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Width of the per-lane extended value: room for one extension bit and the full split.
  function automatic int unsigned calc_w(input int unsigned dw, input int unsigned mwh,
                                         input int unsigned mwl);
    return ((dw + 1) > (mwh + mwl)) ? (dw + 1) : (mwh + mwl);
  endfunction

endpackage

// File: rtl/data_split_pipe_skid_buf.sv
// Two-entry valid/ready register slice: full throughput with a registered upstream ready.
module skid_buf
  import data_split_pkg::*;
#(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [PW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [PW-1:0] o_data
);

  skid_state_e   r_state;
  skid_state_e   w_state_nxt;
  logic [PW-1:0] r_main;
  logic [PW-1:0] r_skid;
  logic [PW-1:0] w_main_nxt;
  logic [PW-1:0] w_skid_nxt;
  logic          r_ready;
  logic          r_valid;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_valid & r_ready;
  assign w_pop  = r_valid & i_ready;

  // Next state and data movement; main always holds the word presented downstream.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_main_nxt  = i_data;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({w_push, w_pop})
          2'b10: begin
            w_skid_nxt  = i_data;
            w_state_nxt = ST_FULL;
          end
          2'b01:   w_state_nxt = ST_EMPTY;
          2'b11:   w_main_nxt  = i_data;
          default: w_state_nxt = ST_ONE;
        endcase
      end
      ST_FULL: begin
        if (w_pop) begin
          w_main_nxt  = r_skid;
          w_state_nxt = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Handshake flags are decoded from the next state so both leave the flops directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_ready <= (w_state_nxt != ST_FULL);
      r_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_main;

endmodule

// File: rtl/data_split_pipe.sv
// Per-lane optional sign extension, high/low field split and truncation overflow,
// registered through a two-entry skid buffer.
module data_split_pipe
  import data_split_pkg::*;
#(
  parameter int unsigned DN  = 6,
  parameter int unsigned DW  = 21,
  parameter int unsigned MWH = 18,
  parameter int unsigned MWL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [DN*DW-1:0]  m_data,
  input  logic              m_signed,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [DN*MWH-1:0] s_data_h,
  output logic [DN*MWL-1:0] s_data_l,
  output logic [DN-1:0]     s_ovf
);

  localparam int unsigned W     = calc_w(DW, MWH, MWL);
  localparam int unsigned LW    = MWH + MWL + 1;
  localparam int unsigned PW    = DN * LW;
  localparam int unsigned NDISC = W - (MWH + MWL);

  logic [PW-1:0] w_pay_in;
  logic [PW-1:0] w_pay_out;

  for (genvar i = 0; i < int'(DN); i++) begin : g_lane
    logic [DW-1:0] w_lane;
    logic [W-1:0]  w_ext;
    logic          w_ovf;

    assign w_lane = m_data[i*DW +: DW];
    assign w_ext  = {{(W-DW){m_signed & w_lane[DW-1]}}, w_lane};

    // Bits above the high field are dropped; flag when they carried information.
    if (NDISC > 0) begin : g_trunc
      logic [NDISC-1:0] w_disc;
      assign w_disc = w_ext[W-1 -: NDISC];
      assign w_ovf  = m_signed ? (w_disc != {NDISC{w_ext[MWH+MWL-1]}}) : (w_disc != '0);
    end else begin : g_no_trunc
      assign w_ovf = 1'b0;
    end

    assign w_pay_in[i*LW +: LW]       = {w_ovf, w_ext[MWL +: MWH], w_ext[MWL-1:0]};
    assign s_data_l[i*MWL +: MWL]     = w_pay_out[i*LW +: MWL];
    assign s_data_h[i*MWH +: MWH]     = w_pay_out[i*LW+MWL +: MWH];
    assign s_ovf[i]                   = w_pay_out[i*LW+MWL+MWH];
  end

  skid_buf #(
    .PW(PW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (m_valid),
    .o_ready (m_ready),
    .i_data  (w_pay_in),
    .o_valid (s_valid),
    .i_ready (s_ready),
    .o_data  (w_pay_out)
  );

endmodule
